// File: rtl/add_sequencer.sv
// Byte-serial adder: one 8-bit add per call, combinational, zero latency.
// Signed overflow is flagged on the o port.
// No flow control; every input change is evaluated immediately.
module adder8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       o
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    assign o         = (a[7] == b[7]) & (s[7] != a[7]);

endmodule

// Multi-precision add/sub that walks one shared adder8bit LSB byte first.
// Latency NBYTES edges from accept to done; one op per NBYTES+2 cycles.
// start is honoured only while ready; requests in RUN/DONE are dropped.
module add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last_byte;
    logic [W-1:0]    a_lat;
    logic [W-1:0]    b_lat;
    logic            carry;
    logic [IDXW-1:0] idx;
    logic [7:0]      add_a;
    logic [7:0]      add_b;
    logic [7:0]      add_s;
    logic            add_cout;
    logic            add_o_unused;

    assign last_byte = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_byte) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Constant-index byte mux keeps every select in range for any NBYTES.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == IDXW'(k)) begin
                add_a = a_lat[8*k +: 8];
                add_b = b_lat[8*k +: 8];
            end
        end
    end

    adder8bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .s    (add_s),
        .cout (add_cout),
        .o    (add_o_unused)
    );

    // Subtract is a + ~b + 1: b is inverted at latch time and the +1 rides in on the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat  <= '0;
            b_lat  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_lat  <= a;
            b_lat  <= op_sub ? ~b : b;
            carry  <= op_sub;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (idx == IDXW'(k)) begin
                    result[8*k +: 8] <= add_s;
                end
            end
            carry <= add_cout;
            idx   <= idx + IDXW'(1);
            if (last_byte) begin
                cout <= add_cout;
                ovf  <= (a_lat[W-1] == b_lat[W-1]) & (add_s[7] != a_lat[W-1]);
            end
        end
    end

endmodule
